// File: rtl/core_mem_rd_arbiter_if.sv
// AXI-lite read channel bundle (AR + R) shared by the fetch master, the
// load/store master and the memory slave port of the read arbiter.
interface core_mem_rd_arbiter_if #(
    parameter int AXI_AWIDTH = 4,
    parameter int AXI_DWIDTH = 32
);
    logic [AXI_AWIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_DWIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    // Side that issues reads (a CPU stage, or the arbiter towards memory)
    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    // Side that answers reads (memory, or the arbiter towards a CPU stage)
    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/core_mem_rd_arbiter.sv
// Two-master (fetch M0, load/store M1) to one-slave AXI-lite read arbiter.
// One read in flight at a time; the granted master sees ARREADY and RVALID
// together at completion. Optional watchdog answers SLVERR for a dead slave.
module core_mem_rd_arbiter #(
    parameter int AXI_AWIDTH  = 4,
    parameter int AXI_DWIDTH  = 32,
    parameter int RR_EN       = 1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                  CLK,
    input  logic                  NRST,
    core_mem_rd_arbiter_if.slave  m0,
    core_mem_rd_arbiter_if.slave  m1,
    core_mem_rd_arbiter_if.master s,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t                state_reg;
    logic                  owner_reg;      // 0: M0 owns the slave, 1: M1
    logic                  pref_m1_reg;    // round-robin: M1 wins the next tie
    logic                  abort_reg;      // owner dropped ARVALID mid-transaction
    logic                  s_arvalid_reg;
    logic                  s_rready_reg;
    logic                  rvalid_reg;
    logic [AXI_AWIDTH-1:0] s_araddr_reg;
    logic [AXI_DWIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;
    logic [1:0]            grant_reg;
    logic [WD_W-1:0]       wd_cnt_reg;

    logic own_arvalid;
    logic own_rready;
    logic pick_m1;
    logic abort_now;
    logic wd_hit;

    assign own_arvalid = owner_reg ? m1.arvalid : m0.arvalid;
    assign own_rready  = owner_reg ? m1.rready  : m0.rready;
    // M1 wins when alone, or on a tie when round-robin prefers it
    assign pick_m1     = m1.arvalid && (!m0.arvalid || ((RR_EN != 0) && pref_m1_reg));
    // Abort is sticky: a re-raised ARVALID must not pick up the old data
    assign abort_now   = abort_reg || !own_arvalid;
    assign wd_hit      = (TIMEOUT_CYC > 0) && (wd_cnt_reg == WD_LAST);

    // Arbitration FSM with all bus outputs registered
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            pref_m1_reg   <= 1'b0;
            abort_reg     <= 1'b0;
            s_arvalid_reg <= 1'b0;
            s_rready_reg  <= 1'b0;
            rvalid_reg    <= 1'b0;
            s_araddr_reg  <= '0;
            rdata_reg     <= '0;
            rresp_reg     <= 2'b00;
            grant_reg     <= 2'b00;
            wd_cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (m0.arvalid || m1.arvalid) begin
                        owner_reg     <= pick_m1;
                        grant_reg     <= pick_m1 ? 2'b10 : 2'b01;
                        s_araddr_reg  <= pick_m1 ? m1.araddr : m0.araddr;
                        s_arvalid_reg <= 1'b1;
                        abort_reg     <= 1'b0;
                        wd_cnt_reg    <= '0;
                        state_reg     <= ADDR;
                    end
                end
                ADDR: begin
                    abort_reg <= abort_now;
                    if (wd_hit) begin
                        // Slave never took the address: answer SLVERR ourselves
                        s_arvalid_reg <= 1'b0;
                        s_rready_reg  <= 1'b0;
                        rdata_reg     <= '0;
                        rresp_reg     <= 2'b10;
                        if (abort_now) begin
                            grant_reg   <= 2'b00;
                            pref_m1_reg <= !owner_reg;
                            state_reg   <= IDLE;
                        end else begin
                            rvalid_reg <= 1'b1;
                            state_reg  <= RESP;
                        end
                    end else if (s.arready) begin
                        s_arvalid_reg <= 1'b0;
                        s_rready_reg  <= 1'b1;
                        wd_cnt_reg    <= wd_cnt_reg + 1'b1;
                        state_reg     <= DATA;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    abort_reg <= abort_now;
                    if (s.rvalid) begin
                        s_rready_reg <= 1'b0;
                        if (abort_now) begin
                            // Consume and discard; the owner no longer wants it
                            grant_reg   <= 2'b00;
                            pref_m1_reg <= !owner_reg;
                            state_reg   <= IDLE;
                        end else begin
                            rdata_reg  <= s.rdata;
                            rresp_reg  <= s.rresp;
                            rvalid_reg <= 1'b1;
                            state_reg  <= RESP;
                        end
                    end else if (wd_hit) begin
                        s_rready_reg <= 1'b0;
                        rdata_reg    <= '0;
                        rresp_reg    <= 2'b10;
                        if (abort_now) begin
                            grant_reg   <= 2'b00;
                            pref_m1_reg <= !owner_reg;
                            state_reg   <= IDLE;
                        end else begin
                            rvalid_reg <= 1'b1;
                            state_reg  <= RESP;
                        end
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    // Normal completion on RREADY, or abort on ARVALID drop
                    if (own_rready || !own_arvalid) begin
                        rvalid_reg  <= 1'b0;
                        rdata_reg   <= '0;
                        rresp_reg   <= 2'b00;
                        grant_reg   <= 2'b00;
                        pref_m1_reg <= !owner_reg;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign s.araddr  = s_araddr_reg;
    assign s.arvalid = s_arvalid_reg;
    assign s.rready  = s_rready_reg;
    assign grant     = grant_reg;

    // Only the granted master sees the completion; the other reads all zeros
    assign m0.arready = rvalid_reg && grant_reg[0];
    assign m0.rvalid  = rvalid_reg && grant_reg[0];
    assign m0.rdata   = grant_reg[0] ? rdata_reg : '0;
    assign m0.rresp   = grant_reg[0] ? rresp_reg : 2'b00;
    assign m1.arready = rvalid_reg && grant_reg[1];
    assign m1.rvalid  = rvalid_reg && grant_reg[1];
    assign m1.rdata   = grant_reg[1] ? rdata_reg : '0;
    assign m1.rresp   = grant_reg[1] ? rresp_reg : 2'b00;

endmodule

// File: tb/tb_core_mem_rd_arbiter.sv
// Directed bench for core_mem_rd_arbiter. dut_a: round-robin, no watchdog.
// dut_b: fixed priority, 8-cycle watchdog. Inputs change on the falling edge,
// outputs are sampled on the falling edge; cycle 0 is the request cycle.
module tb_core_mem_rd_arbiter;
    localparam int AW = 4;
    localparam int DW = 32;

    logic CLK = 1'b0;
    logic NRST = 1'b0;
    always #5 CLK = ~CLK;

    core_mem_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) a_m0 ();
    core_mem_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) a_m1 ();
    core_mem_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) a_s ();
    core_mem_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) b_m0 ();
    core_mem_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) b_m1 ();
    core_mem_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) b_s ();
    logic [1:0] grant_a;
    logic [1:0] grant_b;

    core_mem_rd_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .RR_EN(1), .TIMEOUT_CYC(0)) dut_a (
        .CLK(CLK), .NRST(NRST), .m0(a_m0), .m1(a_m1), .s(a_s), .grant(grant_a));
    core_mem_rd_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .RR_EN(0), .TIMEOUT_CYC(8)) dut_b (
        .CLK(CLK), .NRST(NRST), .m0(b_m0), .m1(b_m1), .s(b_s), .grant(grant_b));

    logic [79:0] snap_a;
    logic [79:0] snap_b;
    assign snap_a = {a_s.arvalid, a_s.rready, a_s.araddr, grant_a,
                     a_m0.arready, a_m0.rvalid, a_m0.rdata, a_m0.rresp,
                     a_m1.arready, a_m1.rvalid, a_m1.rdata, a_m1.rresp};
    assign snap_b = {b_s.arvalid, b_s.rready, b_s.araddr, grant_b,
                     b_m0.arready, b_m0.rvalid, b_m0.rdata, b_m0.rresp,
                     b_m1.arready, b_m1.rvalid, b_m1.rdata, b_m1.rresp};

    int errors = 0;
    int checks = 0;
    int a_r_wait = 0;
    bit b_stall = 1'b0;

    function automatic logic [31:0] data_of(input logic [3:0] addr);
        case (addr)
            4'h8:    return 32'h00500093;
            4'h3:    return 32'hDEADBEEF;
            default: return {28'hA5A5000, addr};
        endcase
    endfunction

    // Slave model for dut_a: takes the address at once, answers after a_r_wait cycles
    initial begin : slave_a
        bit       pend;
        bit       hs;
        int       rcnt;
        logic [3:0] paddr;
        pend = 0; hs = 0; rcnt = 0; paddr = '0;
        a_s.arready = 0; a_s.rvalid = 0; a_s.rdata = '0; a_s.rresp = 2'b00;
        forever begin
            @(negedge CLK);
            if (!NRST) begin
                a_s.arready = 0; a_s.rvalid = 0; a_s.rdata = '0;
                pend = 0; hs = 0;
            end else begin
                a_s.arready = 0;
                if (hs) begin
                    a_s.rvalid = 0; a_s.rdata = '0; pend = 0; hs = 0;
                end else if (!pend) begin
                    if (a_s.arvalid) begin
                        a_s.arready = 1; pend = 1; paddr = a_s.araddr; rcnt = 0;
                    end
                end else if (!a_s.rvalid) begin
                    if (rcnt >= a_r_wait) begin
                        a_s.rvalid = 1; a_s.rdata = data_of(paddr);
                    end else begin
                        rcnt++;
                    end
                end
                if (a_s.rvalid) hs = a_s.rready;
            end
        end
    end

    // Slave model for dut_b: zero-wait, or never accepts while b_stall is set
    initial begin : slave_b
        bit       pend;
        bit       hs;
        logic [3:0] paddr;
        pend = 0; hs = 0; paddr = '0;
        b_s.arready = 0; b_s.rvalid = 0; b_s.rdata = '0; b_s.rresp = 2'b00;
        forever begin
            @(negedge CLK);
            if (!NRST) begin
                b_s.arready = 0; b_s.rvalid = 0; b_s.rdata = '0;
                pend = 0; hs = 0;
            end else begin
                b_s.arready = 0;
                if (hs) begin
                    b_s.rvalid = 0; b_s.rdata = '0; pend = 0; hs = 0;
                end else if (!pend) begin
                    if (b_s.arvalid && !b_stall) begin
                        b_s.arready = 1; pend = 1; paddr = b_s.araddr;
                    end
                end else if (!b_s.rvalid) begin
                    b_s.rvalid = 1; b_s.rdata = data_of(paddr);
                end
                if (b_s.rvalid) hs = b_s.rready;
            end
        end
    end

    task automatic do_reset();
        NRST = 1'b0;
        a_r_wait = 0;
        b_stall = 1'b0;
        a_m0.arvalid = 0; a_m0.araddr = '0; a_m0.rready = 1;
        a_m1.arvalid = 0; a_m1.araddr = '0; a_m1.rready = 1;
        b_m0.arvalid = 0; b_m0.araddr = '0; b_m0.rready = 1;
        b_m1.arvalid = 0; b_m1.araddr = '0; b_m1.rready = 1;
        repeat (2) @(negedge CLK);
        NRST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (snap_a !== 80'd0) begin errors++; $display("FAIL reset_a: got %h want 0", snap_a); end
        checks++; if (snap_b !== 80'd0) begin errors++; $display("FAIL reset_b: got %h want 0", snap_b); end
        $display("test_reset: outputs after reset a=%h b=%h", snap_a, snap_b);
    endtask

    task automatic test_basic();
        do_reset();
        a_m0.araddr = 4'h8; a_m0.arvalid = 1;
        @(negedge CLK); // cycle 1
        checks++; if (a_s.arvalid !== 1'b1) begin errors++; $display("FAIL basic_s_arvalid: got %b want 1", a_s.arvalid); end
        checks++; if (a_s.araddr !== 4'h8) begin errors++; $display("FAIL basic_s_araddr: got %h want 8", a_s.araddr); end
        checks++; if (grant_a !== 2'b01) begin errors++; $display("FAIL basic_grant: got %b want 01", grant_a); end
        @(negedge CLK); // cycle 2
        checks++; if ({a_s.rready, a_m0.rvalid} !== 2'b10) begin errors++; $display("FAIL basic_data_phase: got rready,rvalid=%b want 10", {a_s.rready, a_m0.rvalid}); end
        @(negedge CLK); // cycle 3
        checks++; if ({a_m0.rvalid, a_m0.arready} !== 2'b11) begin errors++; $display("FAIL basic_rvalid_arready: got %b want 11", {a_m0.rvalid, a_m0.arready}); end
        checks++; if (a_m0.rdata !== 32'h00500093) begin errors++; $display("FAIL basic_rdata: got %h want 00500093", a_m0.rdata); end
        checks++; if ({a_m0.rresp, a_m1.rvalid} !== 3'b000) begin errors++; $display("FAIL basic_rresp_m1: got %b want 000", {a_m0.rresp, a_m1.rvalid}); end
        $display("test_basic: M0 read addr 8 -> %h", a_m0.rdata);
        a_m0.arvalid = 0;
        @(negedge CLK); // cycle 4
        checks++; if ({grant_a, a_m0.rvalid} !== 3'b000) begin errors++; $display("FAIL basic_idle: got grant,rvalid=%b want 000", {grant_a, a_m0.rvalid}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        a_m0.araddr = 4'h8; a_m0.arvalid = 1;
        repeat (3) @(negedge CLK); // cycle 3
        checks++; if ({a_m0.rvalid, a_m0.rdata} !== {1'b1, 32'h00500093}) begin errors++; $display("FAIL b2b_first: got %b/%h want 1/00500093", a_m0.rvalid, a_m0.rdata); end
        $display("test_back_to_back: M0 read addr 8 -> %h", a_m0.rdata);
        a_m0.araddr = 4'hC;
        @(negedge CLK); // cycle 4
        checks++; if ({a_s.arvalid, grant_a} !== 3'b000) begin errors++; $display("FAIL b2b_gap: got arvalid,grant=%b want 000", {a_s.arvalid, grant_a}); end
        @(negedge CLK); // cycle 5
        checks++; if ({a_s.arvalid, a_s.araddr} !== {1'b1, 4'hC}) begin errors++; $display("FAIL b2b_second_addr: got %b/%h want 1/c", a_s.arvalid, a_s.araddr); end
        repeat (2) @(negedge CLK); // cycle 7
        checks++; if ({a_m0.rvalid, a_m0.rdata} !== {1'b1, 32'hA5A5000C}) begin errors++; $display("FAIL b2b_second: got %b/%h want 1/a5a5000c", a_m0.rvalid, a_m0.rdata); end
        $display("test_back_to_back: M0 read addr c -> %h", a_m0.rdata);
        a_m0.arvalid = 0;
        @(negedge CLK);
    endtask

    task automatic test_round_robin();
        do_reset();
        a_m0.araddr = 4'h1; a_m1.araddr = 4'h2; a_m0.arvalid = 1; a_m1.arvalid = 1;
        b_m0.araddr = 4'h1; b_m1.araddr = 4'h2; b_m0.arvalid = 1; b_m1.arvalid = 1;
        @(negedge CLK); // cycle 1
        checks++; if (grant_a !== 2'b01) begin errors++; $display("FAIL rr_first_grant: got %b want 01", grant_a); end
        checks++; if (grant_b !== 2'b01) begin errors++; $display("FAIL fp_first_grant: got %b want 01", grant_b); end
        repeat (2) @(negedge CLK); // cycle 3
        checks++; if ({b_m0.rvalid, b_m0.rdata} !== {1'b1, 32'hA5A50001}) begin errors++; $display("FAIL fp_first_data: got %b/%h want 1/a5a50001", b_m0.rvalid, b_m0.rdata); end
        checks++; if ({a_m1.rvalid, a_m1.arready, a_m1.rdata} !== 34'd0) begin errors++; $display("FAIL rr_loser_quiet: got %b/%b/%h want 0/0/0", a_m1.rvalid, a_m1.arready, a_m1.rdata); end
        repeat (2) @(negedge CLK); // cycle 5
        checks++; if ({grant_a, a_s.araddr} !== {2'b10, 4'h2}) begin errors++; $display("FAIL rr_second_grant: got %b/%h want 10/2", grant_a, a_s.araddr); end
        checks++; if (grant_b !== 2'b01) begin errors++; $display("FAIL fp_second_grant: got %b want 01", grant_b); end
        repeat (2) @(negedge CLK); // cycle 7
        checks++; if ({a_m1.rvalid, a_m1.rdata, a_m0.rvalid} !== {1'b1, 32'hA5A50002, 1'b0}) begin errors++; $display("FAIL rr_second_data: got %b/%h/%b want 1/a5a50002/0", a_m1.rvalid, a_m1.rdata, a_m0.rvalid); end
        $display("test_round_robin: M1 read addr 2 -> %h", a_m1.rdata);
        a_m0.arvalid = 0; a_m1.arvalid = 0; b_m0.arvalid = 0; b_m1.arvalid = 0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_busy_other();
        do_reset();
        a_r_wait = 5;
        a_m1.araddr = 4'h5; a_m1.arvalid = 1;
        @(negedge CLK); // cycle 1
        checks++; if (grant_a !== 2'b10) begin errors++; $display("FAIL busy_m1_grant: got %b want 10", grant_a); end
        @(negedge CLK); // cycle 2
        a_m0.araddr = 4'h6; a_m0.arvalid = 1;
        for (int c = 2; c < 8; c++) begin
            checks++;
            if ({a_m0.arready, a_m0.rvalid, a_m0.rdata, a_m0.rresp, a_m1.rvalid} !== 37'd0) begin
                errors++; $display("FAIL busy_wait_c%0d: got m0 %b/%b/%h m1 rvalid %b want all 0", c, a_m0.arready, a_m0.rvalid, a_m0.rdata, a_m1.rvalid);
            end
            @(negedge CLK);
        end
        // cycle 8
        checks++; if ({a_m1.rvalid, a_m1.rdata, a_m0.rvalid} !== {1'b1, 32'hA5A50005, 1'b0}) begin errors++; $display("FAIL busy_m1_data: got %b/%h m0 %b want 1/a5a50005/0", a_m1.rvalid, a_m1.rdata, a_m0.rvalid); end
        $display("test_busy_other: M1 read addr 5 -> %h", a_m1.rdata);
        a_m1.arvalid = 0;
        @(negedge CLK); // cycle 9
        a_r_wait = 0;
        checks++; if (grant_a !== 2'b00) begin errors++; $display("FAIL busy_exit_idle: got %b want 00", grant_a); end
        @(negedge CLK); // cycle 10
        checks++; if ({grant_a, a_s.araddr} !== {2'b01, 4'h6}) begin errors++; $display("FAIL busy_m0_grant: got %b/%h want 01/6", grant_a, a_s.araddr); end
        repeat (2) @(negedge CLK); // cycle 12
        checks++; if ({a_m0.rvalid, a_m0.rdata} !== {1'b1, 32'hA5A50006}) begin errors++; $display("FAIL busy_m0_data: got %b/%h want 1/a5a50006", a_m0.rvalid, a_m0.rdata); end
        $display("test_busy_other: M0 read addr 6 -> %h", a_m0.rdata);
        a_m0.arvalid = 0;
        @(negedge CLK);
    endtask

    task automatic test_abort();
        do_reset();
        a_r_wait = 2;
        a_m0.araddr = 4'h3; a_m0.arvalid = 1;
        repeat (2) @(negedge CLK); // cycle 2
        checks++; if (a_s.rready !== 1'b1) begin errors++; $display("FAIL abort_in_data: got rready %b want 1", a_s.rready); end
        a_m0.arvalid = 0;
        for (int c = 3; c <= 8; c++) begin
            @(negedge CLK);
            checks++;
            if ({a_m0.rvalid, a_m0.arready, a_m0.rdata} !== 34'd0) begin
                errors++; $display("FAIL abort_no_resp_c%0d: got %b/%b/%h want 0/0/0", c, a_m0.rvalid, a_m0.arready, a_m0.rdata);
            end
        end
        checks++; if ({grant_a, a_s.rready, a_s.arvalid} !== 4'b0000) begin errors++; $display("FAIL abort_idle: got %b want 0000", {grant_a, a_s.rready, a_s.arvalid}); end
        a_r_wait = 0;
        a_m0.araddr = 4'hC; a_m0.arvalid = 1;
        @(negedge CLK); // cycle 1'
        checks++; if ({grant_a, a_s.araddr} !== {2'b01, 4'hC}) begin errors++; $display("FAIL abort_rereq_addr: got %b/%h want 01/c", grant_a, a_s.araddr); end
        repeat (2) @(negedge CLK); // cycle 3'
        checks++; if ({a_m0.rvalid, a_m0.rdata} !== {1'b1, 32'hA5A5000C}) begin errors++; $display("FAIL abort_fresh_data: got %b/%h want 1/a5a5000c", a_m0.rvalid, a_m0.rdata); end
        $display("test_abort: M0 re-read addr c -> %h", a_m0.rdata);
        a_m0.arvalid = 0;
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        do_reset();
        b_stall = 1'b1;
        b_m0.araddr = 4'h7; b_m0.arvalid = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            checks++;
            if ({b_s.arvalid, b_m0.rvalid} !== 2'b10) begin
                errors++; $display("FAIL timeout_wait_c%0d: got arvalid,rvalid=%b want 10", c, {b_s.arvalid, b_m0.rvalid});
            end
        end
        @(negedge CLK); // cycle 9
        checks++; if ({b_m0.rvalid, b_m0.arready, b_m0.rresp} !== 4'b1110) begin errors++; $display("FAIL timeout_resp: got rvalid,arready,rresp=%b want 1110", {b_m0.rvalid, b_m0.arready, b_m0.rresp}); end
        checks++; if (b_m0.rdata !== 32'd0) begin errors++; $display("FAIL timeout_rdata: got %h want 0", b_m0.rdata); end
        checks++; if ({b_s.arvalid, b_s.rready} !== 2'b00) begin errors++; $display("FAIL timeout_s_drop: got %b want 00", {b_s.arvalid, b_s.rready}); end
        $display("test_timeout: M0 read addr 7 -> rresp %b rdata %h", b_m0.rresp, b_m0.rdata);
        b_m0.arvalid = 0; b_stall = 1'b0;
        @(negedge CLK); // cycle 10
        checks++; if (grant_b !== 2'b00) begin errors++; $display("FAIL timeout_exit: got %b want 00", grant_b); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_r_wait = 3;
        a_m0.araddr = 4'h9; a_m0.arvalid = 1;
        repeat (2) @(negedge CLK); // cycle 2, in DATA
        checks++; if (a_s.rready !== 1'b1) begin errors++; $display("FAIL rstmid_in_data: got rready %b want 1", a_s.rready); end
        NRST = 1'b0; a_m0.arvalid = 0;
        @(negedge CLK); // cycle 3
        checks++; if (snap_a !== 80'd0) begin errors++; $display("FAIL rstmid_outputs: got %h want 0", snap_a); end
        @(negedge CLK);
        NRST = 1'b1; a_r_wait = 0;
        a_m0.araddr = 4'h8; a_m0.arvalid = 1;
        @(negedge CLK); // cycle 1
        checks++; if ({a_s.arvalid, a_s.araddr, grant_a} !== {1'b1, 4'h8, 2'b01}) begin errors++; $display("FAIL rstmid_rereq: got %b/%h/%b want 1/8/01", a_s.arvalid, a_s.araddr, grant_a); end
        repeat (2) @(negedge CLK); // cycle 3
        checks++; if ({a_m0.rvalid, a_m0.rdata} !== {1'b1, 32'h00500093}) begin errors++; $display("FAIL rstmid_data: got %b/%h want 1/00500093", a_m0.rvalid, a_m0.rdata); end
        $display("test_reset_mid: M0 read addr 8 after reset -> %h", a_m0.rdata);
        a_m0.arvalid = 0;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_round_robin();
        test_busy_other();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
